// File: rtl/adc_serial_capture.sv
// adc_serial_capture
//   Drives a dual-channel serial ADC (shared CS_n/SCLK, one data line per
//   channel) in continuous frames and publishes one sample pair per frame.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   en           continuous-sampling enable
//   test_pat     (only with ADC_TEST_PATTERN_EN) publish a counter pattern
//                instead of the serial data
//   adc_cs_n     ADC chip select, active low, registered
//   adc_sclk     ADC serial clock, idles high, registered
//   adc_sdata_a  serial data channel A, MSB first
//   adc_sdata_b  serial data channel B, MSB first
//   adc_out_a    last captured sample, channel A
//   adc_out_b    last captured sample, channel B
//   conv_done    new-sample strobe, high for two clk cycles per frame
//   busy         high while adc_cs_n is low
//   frame_cnt    completed-frame counter, wraps
//
// Build option
//   ADC_TEST_PATTERN_EN  adds test_pat; when high at frame completion,
//                        adc_out_a = new frame count, adc_out_b = its inverse.
//
// state | meaning
// IDLE  | sampling disabled, CS_n and SCLK high
// QUIET | CS_n high for QUIET_CYCLES between frames
// SHIFT | CS_n low, FRAME_BITS SCLK periods, data sampled on SCLK rise
// DONE  | CS_n high, sample published, frame counted
module adc_serial_capture #(
  parameter int SIG_WIDTH    = 12,
  parameter int CLK_DIV      = 2,
  parameter int FRAME_BITS   = 16,
  parameter int LEAD_BITS    = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                 test_pat,
`endif
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  input  logic                 adc_sdata_a,
  input  logic                 adc_sdata_b,
  output logic [SIG_WIDTH-1:0] adc_out_a,
  output logic [SIG_WIDTH-1:0] adc_out_b,
  output logic                 conv_done,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam int TMR_MAX = (QUIET_CYCLES > CLK_DIV) ? QUIET_CYCLES : CLK_DIV;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int BW      = $clog2(FRAME_BITS + 1);

  localparam logic [TW-1:0] QUIET_LOAD = TW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LOAD  = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD   = BW'(FRAME_BITS - 1);
  // bits_left counts down, so bit index b = FRAME_BITS-1-bits_left; the
  // capture window b = LEAD_BITS .. LEAD_BITS+SIG_WIDTH-1 maps to these bounds.
  localparam logic [BW-1:0] CAP_HI     = BW'(FRAME_BITS - 1 - LEAD_BITS);
  localparam logic [BW-1:0] CAP_LO     = BW'(FRAME_BITS - LEAD_BITS - SIG_WIDTH);

  typedef enum logic [1:0] {IDLE, QUIET, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [BW-1:0]         bits_left_q, bits_left_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  conv_done_q, conv_done_d;
  logic [SIG_WIDTH-1:0]  sh_a_q, sh_a_d;
  logic [SIG_WIDTH-1:0]  sh_b_q, sh_b_d;
  logic [SIG_WIDTH-1:0]  out_a_q, out_a_d;
  logic [SIG_WIDTH-1:0]  out_b_q, out_b_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  in_window;

  assign in_window = (bits_left_q >= CAP_LO) && (bits_left_q <= CAP_HI);

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bits_left_d = bits_left_q;
    sclk_d      = sclk_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = QUIET;
          tmr_d   = QUIET_LOAD;
        end
      end
      QUIET: begin
        if (!en) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          state_d     = SHIFT;
          tmr_d       = HALF_LOAD;
          bits_left_d = BIT_LOAD;
          sclk_d      = 1'b0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      SHIFT: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (!sclk_q) begin
          // end of low phase: SCLK rises on this edge, sample here
          sclk_d = 1'b1;
          tmr_d  = HALF_LOAD;
          if (in_window) begin
            sh_a_d = {sh_a_q[SIG_WIDTH-2:0], adc_sdata_a};
            sh_b_d = {sh_b_q[SIG_WIDTH-2:0], adc_sdata_b};
          end
        end else if (bits_left_q == '0) begin
          // end of last high phase: frame complete
          state_d     = DONE;
          frame_cnt_d = frame_cnt_q + 16'd1;
          out_a_d     = sh_a_q;
          out_b_d     = sh_b_q;
`ifdef ADC_TEST_PATTERN_EN
          if (test_pat) begin
            out_a_d = frame_cnt_d[SIG_WIDTH-1:0];
            out_b_d = ~frame_cnt_d[SIG_WIDTH-1:0];
          end
`endif
        end else begin
          sclk_d      = 1'b0;
          tmr_d       = HALF_LOAD;
          bits_left_d = bits_left_q - BW'(1);
        end
      end
      DONE: begin
        if (en) begin
          state_d = QUIET;
          tmr_d   = QUIET_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // CS_n, SCLK and busy are registered from the next state so each pin
    // comes straight off a flop and busy tracks CS_n edge for edge.
    if (state_d != SHIFT) sclk_d = 1'b1;
    cs_n_d      = (state_d != SHIFT);
    busy_d      = (state_d == SHIFT);
    // DONE cycle plus the one after it
    conv_done_d = (state_d == DONE) || (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      bits_left_q <= '0;
      sclk_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      conv_done_q <= 1'b0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bits_left_q <= bits_left_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      conv_done_q <= conv_done_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign busy      = busy_q;
  assign conv_done = conv_done_q;
  assign adc_out_a = out_a_q;
  assign adc_out_b = out_b_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/adc_serial_capture.md
ADC_SERIAL_CAPTURE -- requirements
Module: adc_serial_capture

Interface
REQ-001 Parameter SIG_WIDTH, default 12, sample width per channel.
REQ-002 Parameter CLK_DIV, default 2, clk cycles per SCLK half-period (>=1).
REQ-003 Parameter FRAME_BITS, default 16, SCLK cycles per conversion frame.
REQ-004 Parameter LEAD_BITS, default 2, leading bits discarded before MSB (LEAD_BITS+SIG_WIDTH <= FRAME_BITS).
REQ-005 Parameter QUIET_CYCLES, default 4, clk cycles CS_n held high between frames (>=1).
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 en  input  1  continuous-sampling enable.
REQ-009 adc_cs_n  output  1  ADC chip select, active-low.
REQ-010 adc_sclk  output  1  ADC serial clock, idles high.
REQ-011 adc_sdata_a / adc_sdata_b  input  1 each  serial data, channels A/B, MSB first.
REQ-012 adc_out_a / adc_out_b  output  SIG_WIDTH each  last captured samples (unsigned).
REQ-013 conv_done  output  1  new-sample strobe, feeds downstream FIR conv_done.
REQ-014 busy  output  1  high while CS_n is low.
REQ-015 frame_cnt  output  16  completed-frame counter.

Function
REQ-016 FSM SHALL have states IDLE, QUIET, SHIFT, DONE; IDLE->QUIET when en=1.
REQ-017 QUIET: CS_n=1, SCLK=1, count QUIET_CYCLES clk cycles, then ->SHIFT.
REQ-018 SHIFT: CS_n=0; SCLK low CLK_DIV cycles then high CLK_DIV cycles, repeated FRAME_BITS times (2*CLK_DIV*FRAME_BITS clk cycles total).
REQ-019 Sampling SHALL occur on the clk edge where adc_sclk goes 0->1; bit index b counts 0..FRAME_BITS-1.
REQ-020 Bits b = LEAD_BITS .. LEAD_BITS+SIG_WIDTH-1 SHALL shift into per-channel shift registers MSB first; others ignored.
REQ-021 After last SCLK high phase ->DONE: CS_n=1, adc_out_a/b loaded from shift registers, frame_cnt += 1 (wraps 0xFFFF->0), conv_done=1.
REQ-022 conv_done SHALL be high exactly 2 clk cycles (DONE plus next cycle) so a synchroniser-based edge detector downstream sees one rising edge per frame.
REQ-023 Outputs adc_out_a/b SHALL be stable from DONE until next DONE.
REQ-024 DONE->QUIET if en=1, else ->IDLE.
REQ-025 en deasserted during QUIET SHALL return to IDLE; during SHIFT the frame SHALL complete and publish, then IDLE.
REQ-026 busy SHALL equal ~adc_cs_n registered identically (no glitch).
REQ-027 adc_cs_n and adc_sclk SHALL be driven from flops, glitch-free.

Reset
REQ-028 On rst: state IDLE, adc_cs_n=1, adc_sclk=1, conv_done=0, busy=0, adc_out_a/b=0, frame_cnt=0, shift registers=0.
REQ-029 rst mid-SHIFT SHALL abort the frame immediately; no partial sample published, frame_cnt unchanged beyond clear.
REQ-030 After rst release with en=1, first CS_n falling edge SHALL occur after QUIET_CYCLES+1 clk cycles.

Configuration
REQ-031 Macro ADC_TEST_PATTERN_EN: when defined, adds input test_pat (1 bit); if test_pat=1 at DONE, adc_out_a = frame_cnt_next[SIG_WIDTH-1:0], adc_out_b = ~frame_cnt_next[SIG_WIDTH-1:0], ADC still clocked normally.
REQ-032 Without ADC_TEST_PATTERN_EN: no test_pat port, outputs always from serial data.

Verification (defaults)
REQ-033 rst release, en=1, ADC model returns A=0xABC, B=0x123 -> CS_n low 64 clk cycles, 16 SCLK rising edges, adc_out_a=0xABC, adc_out_b=0x123, conv_done high 2 cycles, frame_cnt=1.
REQ-034 Continuous en=1, 3 frames -> frame period 64+1+4 = 69 clk cycles, 3 conv_done pulses, frame_cnt=3.
REQ-035 en dropped at SHIFT bit 5 -> frame completes, sample published, FSM IDLE, CS_n stays high.
REQ-036 rst asserted at SHIFT bit 8 -> CS_n=1, SCLK=1, outputs 0 same cycle; no conv_done.
REQ-037 Leading bits driven 1, trailing bits 1, data 0x000 -> adc_out=0x000 (lead/trail ignored).
REQ-038 ADC_TEST_PATTERN_EN, test_pat=1, 2 frames -> adc_out_a=0x001 then 0x002, adc_out_b=0xFFE then 0xFFD.
